// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline stall/flush sequencer
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    DRAIN  = 3'd1,
    HALTED = 3'd2
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO      = 5'd0;
  localparam int         CNT_W_DEFAULT = 12;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use hazard detection between the ID and EX stages
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs_num_id,
  input  logic [4:0] rt_num_id,
  input  logic       uses_rs_id,
  input  logic       uses_rt_id,
  input  logic       MemRead_id_ex,
  input  logic [4:0] regfile_write_num_id_ex,
  output logic       load_use
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = uses_rs_id && (rs_num_id == regfile_write_num_id_ex);
  assign rt_hit = uses_rt_id && (rt_num_id == regfile_write_num_id_ex);

  // $0 is hardwired, so a load targeting it never produces a dependency
  assign load_use = MemRead_id_ex && (regfile_write_num_id_ex != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush/freeze sequencer and performance counters for the 5-stage pipeline
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEFAULT,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs_num_id,
  input  logic [4:0]       rt_num_id,
  input  logic             uses_rs_id,
  input  logic             uses_rt_id,
  input  logic             MemRead_id_ex,
  input  logic [4:0]       regfile_write_num_id_ex,
  input  logic             redirect_ex,
  input  logic             halt_id,
  input  logic             mem_req_ex_mem,
  input  logic             mem_ready,
  input  logic             halt_mem_wb,
  output logic             hold_pc,
  output logic             hold_if_id,
  output logic             flush_if_id,
  output logic             hold_id_ex,
  output logic             bubble_id_ex,
  output logic             hold_ex_mem,
  output logic             bubble_mem_wb,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] cycles_counter,
  output logic [CNT_W-1:0] stall_counter,
  output logic [CNT_W-1:0] flush_counter
);

  localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  ctrl_state_t   state_q;
  logic [DW-1:0] drain_cnt;
  logic          load_use;
  logic          mem_wait;

  hazard_detect u_hazard_detect (
    .rs_num_id               (rs_num_id),
    .rt_num_id               (rt_num_id),
    .uses_rs_id              (uses_rs_id),
    .uses_rt_id              (uses_rt_id),
    .MemRead_id_ex           (MemRead_id_ex),
    .regfile_write_num_id_ex (regfile_write_num_id_ex),
    .load_use                (load_use)
  );

  assign mem_wait = mem_req_ex_mem && !mem_ready;
  assign state    = state_q;

  // A MEM wait freezes everything upstream, so redirects and hazards wait until it releases
  always_comb begin
    hold_pc       = 1'b0;
    hold_if_id    = 1'b0;
    flush_if_id   = 1'b0;
    hold_id_ex    = 1'b0;
    bubble_id_ex  = 1'b0;
    hold_ex_mem   = 1'b0;
    bubble_mem_wb = 1'b0;
    halted        = 1'b0;
    if (!rst) begin
      if (state_q == HALTED) begin
        hold_pc       = 1'b1;
        hold_if_id    = 1'b1;
        hold_id_ex    = 1'b1;
        hold_ex_mem   = 1'b1;
        bubble_mem_wb = 1'b1;
        halted        = 1'b1;
      end else if (mem_wait) begin
        hold_pc       = 1'b1;
        hold_if_id    = 1'b1;
        hold_id_ex    = 1'b1;
        hold_ex_mem   = 1'b1;
        bubble_mem_wb = 1'b1;
      end else if (state_q == DRAIN) begin
        hold_pc     = 1'b1;
        flush_if_id = 1'b1;
      end else if (redirect_ex) begin
        flush_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
      end else if (load_use) begin
        hold_pc      = 1'b1;
        hold_if_id   = 1'b1;
        bubble_id_ex = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      drain_cnt      <= '0;
      cycles_counter <= CNT_W'(1);
      stall_counter  <= '0;
      flush_counter  <= '0;
    end else begin
      case (state_q)
        RUN: begin
          // A halt alongside a redirect is on the wrong path and gets flushed
          if (halt_id && !mem_wait && !redirect_ex) begin
            state_q   <= DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          if (halt_mem_wb) begin
            state_q <= HALTED;
          end else if (!mem_wait && (drain_cnt != '0)) begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        HALTED: state_q <= HALTED;
        default: state_q <= RUN;
      endcase

      if ((state_q != HALTED) && !halt_mem_wb && (cycles_counter != '1))
        cycles_counter <= cycles_counter + CNT_W'(1);
      if (hold_pc && (state_q != HALTED) && (stall_counter != '1))
        stall_counter <= stall_counter + CNT_W'(1);
      if (flush_if_id && (flush_counter != '1))
        flush_counter <= flush_counter + CNT_W'(1);

      assert (!((state_q == DRAIN) && (drain_cnt == '0) && !halt_mem_wb));
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - randomized self-checking bench for pipeline_ctrl against a behavioural model
module tb_pipeline_ctrl;

  localparam int CNT_MAX = (1 << 12) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_num_id, rt_num_id, regfile_write_num_id_ex;
  logic        uses_rs_id, uses_rt_id, MemRead_id_ex, redirect_ex, halt_id;
  logic        mem_req_ex_mem, mem_ready, halt_mem_wb;
  logic        hold_pc, hold_if_id, flush_if_id, hold_id_ex, bubble_id_ex, hold_ex_mem, bubble_mem_wb;
  logic [2:0]  state;
  logic        halted;
  logic [11:0] cycles_counter, stall_counter, flush_counter;

  int n_tests = 0;
  int n_fail  = 0;

  // model: mode 0=running, 1=draining, 2=halted; adv = pipeline advances since drain began
  int m_mode, m_adv, m_cyc, m_stall, m_flush;

  pipeline_ctrl dut (
    .clk                     (clk),
    .rst                     (rst),
    .rs_num_id               (rs_num_id),
    .rt_num_id               (rt_num_id),
    .uses_rs_id              (uses_rs_id),
    .uses_rt_id              (uses_rt_id),
    .MemRead_id_ex           (MemRead_id_ex),
    .regfile_write_num_id_ex (regfile_write_num_id_ex),
    .redirect_ex             (redirect_ex),
    .halt_id                 (halt_id),
    .mem_req_ex_mem          (mem_req_ex_mem),
    .mem_ready               (mem_ready),
    .halt_mem_wb             (halt_mem_wb),
    .hold_pc                 (hold_pc),
    .hold_if_id              (hold_if_id),
    .flush_if_id             (flush_if_id),
    .hold_id_ex              (hold_id_ex),
    .bubble_id_ex            (bubble_id_ex),
    .hold_ex_mem             (hold_ex_mem),
    .bubble_mem_wb           (bubble_mem_wb),
    .state                   (state),
    .halted                  (halted),
    .cycles_counter          (cycles_counter),
    .stall_counter           (stall_counter),
    .flush_counter           (flush_counter)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic clear_inputs();
    rs_num_id = 0; rt_num_id = 0; regfile_write_num_id_ex = 0;
    uses_rs_id = 0; uses_rt_id = 0; MemRead_id_ex = 0; redirect_ex = 0;
    halt_id = 0; mem_req_ex_mem = 0; mem_ready = 0; halt_mem_wb = 0;
  endtask

  // one cycle: compare at negedge against the model, advance the model, move past the edge
  task automatic step();
    logic [7:0] e;
    bit mw, hz;
    @(negedge clk);
    mw = mem_req_ex_mem && !mem_ready;
    hz = MemRead_id_ex && (regfile_write_num_id_ex != 0) &&
         ((uses_rs_id && rs_num_id == regfile_write_num_id_ex) ||
          (uses_rt_id && rt_num_id == regfile_write_num_id_ex));
    // bits: hold_pc hold_if_id flush_if_id hold_id_ex bubble_id_ex hold_ex_mem bubble_mem_wb halted
    if (rst)              e = 8'b0000_0000;
    else if (m_mode == 2) e = 8'b1101_0111;
    else if (mw)          e = 8'b1101_0110;
    else if (m_mode == 1) e = 8'b1010_0000;
    else if (redirect_ex) e = 8'b0010_1000;
    else if (hz)          e = 8'b1100_1000;
    else                  e = 8'b0000_0000;
    check("ctrl", {hold_pc, hold_if_id, flush_if_id, hold_id_ex, bubble_id_ex,
                   hold_ex_mem, bubble_mem_wb, halted}, e);
    check("state", state, m_mode);
    check("cycles", cycles_counter, m_cyc);
    check("stalls", stall_counter, m_stall);
    check("flushes", flush_counter, m_flush);
    if (rst) begin
      m_mode = 0; m_adv = 0; m_cyc = 1; m_stall = 0; m_flush = 0;
    end else begin
      if (m_mode != 2 && !halt_mem_wb) m_cyc = sat(m_cyc + 1);
      if (e[7] && m_mode != 2) m_stall = sat(m_stall + 1);
      if (e[5]) m_flush = sat(m_flush + 1);
      if (m_mode == 0 && halt_id && !mw && !redirect_ex) begin
        m_mode = 1; m_adv = 0;
      end else if (m_mode == 1) begin
        if (halt_mem_wb) m_mode = 2;
        else if (!mw) m_adv++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic rand_inputs(input bit allow_halt);
    rs_num_id = 5'($urandom_range(0, 3));
    rt_num_id = 5'($urandom_range(0, 3));
    regfile_write_num_id_ex = 5'($urandom_range(0, 3));
    uses_rs_id = 1'($urandom_range(0, 1));
    uses_rt_id = 1'($urandom_range(0, 1));
    MemRead_id_ex = 1'($urandom_range(0, 1));
    redirect_ex = ($urandom_range(0, 5) == 0);
    mem_req_ex_mem = ($urandom_range(0, 2) == 0);
    mem_ready = 1'($urandom_range(0, 1));
    halt_id = allow_halt && (m_mode == 0) && ($urandom_range(0, 30) == 0);
    // the halt lands in MEM/WB after two more advances once draining
    halt_mem_wb = (m_mode == 1) && (m_adv == 2);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    @(posedge clk);
    #1;
    m_mode = 0; m_adv = 0; m_cyc = 1; m_stall = 0; m_flush = 0;
    step();

    // load-use on $8
    do_reset();
    MemRead_id_ex = 1; regfile_write_num_id_ex = 8; rs_num_id = 8; uses_rs_id = 1;
    step();
    clear_inputs();
    step();
    check("lu_stall_cnt", stall_counter, 1);

    // load to $0 read as $0
    do_reset();
    MemRead_id_ex = 1; regfile_write_num_id_ex = 0; rs_num_id = 0; rt_num_id = 0;
    uses_rs_id = 1; uses_rt_id = 1;
    step();
    step();
    check("r0_stall_cnt", stall_counter, 0);

    // redirect beats load-use
    do_reset();
    MemRead_id_ex = 1; regfile_write_num_id_ex = 8; rt_num_id = 8; uses_rt_id = 1; redirect_ex = 1;
    step();
    clear_inputs();
    check("rd_flush_cnt", flush_counter, 1);
    check("rd_stall_cnt", stall_counter, 0);

    // MEM wait masks a redirect for 4 cycles
    do_reset();
    mem_req_ex_mem = 1; mem_ready = 0; redirect_ex = 1;
    repeat (4) step();
    check("mw_flush_cnt", flush_counter, 0);
    check("mw_stall_cnt", stall_counter, 4);
    mem_ready = 1;
    step();
    check("mw_flush_after", flush_counter, 1);

    // halt drain
    do_reset();
    halt_id = 1;
    step();
    halt_id = 0;
    step();
    step();
    halt_mem_wb = 1;
    step();
    halt_mem_wb = 0;
    repeat (3) step();
    check("halt_cycles", cycles_counter, 4);
    check("halt_flag", halted, 1);
    check("halt_state", state, 2);

    // reset mid-drain
    do_reset();
    halt_id = 1;
    step();
    halt_id = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    check("rst_state", state, 0);
    check("rst_cycles", cycles_counter, 1);
    check("rst_hold_pc", hold_pc, 0);

    // long run to saturate the cycle counter
    do_reset();
    for (int i = 0; i < 4200; i++) begin
      rand_inputs(1'b0);
      step();
    end
    check("cyc_sat", cycles_counter, CNT_MAX);

    // random halts, drains and resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rand_inputs(1'b1);
      rst = ((m_mode == 2) && ($urandom_range(0, 7) == 0)) || ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
